// File: rtl/pwm_capture.sv
// Receiving end of the two-channel 7-bit PWM DAC link: measures the duty of PW_1/PW_2
// over free-running frames and rebuilds the 16-bit word that was written to the DAC.
module pwm_capture #(
    parameter int FRAME_BITS = 7
) (
    input  logic        XCK,
    input  logic        RESETL,
    input  logic        PW_1,
    input  logic        PW_2,
    input  logic        RDL,
    output logic [15:0] SAMPLE,
    output logic        VALID,
    output logic        OVERRUN
);
    // FRAME_BITS is expected to be at least 7 (frame must match the 128-clock PWM period).
    localparam int AW = FRAME_BITS + 1;
    localparam logic [AW:0] SAT = (AW + 1)'(127);
    localparam logic [FRAME_BITS-1:0] FCNT_ONE = 1;
    localparam logic [AW-1:0] ACC_ONE = 1;

    logic                  pw1_meta;
    logic                  pw2_meta;
    logic                  s1;
    logic                  s2;
    logic [FRAME_BITS-1:0] fcnt;
    logic [AW-1:0]         acc1;
    logic [AW-1:0]         acc2;
    logic [6:0]            prev1;
    logic [6:0]            prev2;
    logic                  primed;
    logic                  rdl_q;

    logic [AW:0]           tot1;
    logic [AW:0]           tot2;
    logic [6:0]            r1;
    logic [6:0]            r2;
    logic                  terminal;
    logic                  stable;
    logic [15:0]           cand;
    logic                  load;
    logic                  rd_edge;

    always_comb begin
        tot1     = {1'b0, acc1} + {{AW{1'b0}}, s1};
        tot2     = {1'b0, acc2} + {{AW{1'b0}}, s2};
        r1       = (tot1 > SAT) ? 7'h7f : tot1[6:0];
        r2       = (tot2 > SAT) ? 7'h7f : tot2[6:0];
        terminal = (fcnt == '1);
        stable   = (r1 == prev1) && (r2 == prev2);
        cand     = {~r2[6], r2[5:0], r1, 2'b00};
        load     = terminal && stable && (!primed || (cand != SAMPLE));
        rd_edge  = !RDL && rdl_q;
    end

    always_ff @(posedge XCK or negedge RESETL) begin
        if (!RESETL) begin
            pw1_meta <= 1'b0;
            pw2_meta <= 1'b0;
            s1       <= 1'b0;
            s2       <= 1'b0;
        end else begin
            pw1_meta <= PW_1;
            pw2_meta <= PW_2;
            s1       <= pw1_meta;
            s2       <= pw2_meta;
        end
    end

    // The terminal cycle folds its own input into the result, so a frame spans all 2^FRAME_BITS samples.
    always_ff @(posedge XCK or negedge RESETL) begin
        if (!RESETL) begin
            fcnt  <= '0;
            acc1  <= '0;
            acc2  <= '0;
            prev1 <= '0;
            prev2 <= '0;
        end else begin
            fcnt <= fcnt + FCNT_ONE;
            if (terminal) begin
                acc1  <= '0;
                acc2  <= '0;
                prev1 <= r1;
                prev2 <= r2;
            end else begin
                if (s1) acc1 <= acc1 + ACC_ONE;
                if (s2) acc2 <= acc2 + ACC_ONE;
            end
        end
    end

    // Handshake: VALID rises on every load and stays until the first clock that samples RDL
    // low after it was high; a load in that same clock wins, and OVERRUN then stays clear
    // because the read consumed the previous word.
    always_ff @(posedge XCK or negedge RESETL) begin
        if (!RESETL) begin
            SAMPLE  <= 16'h0000;
            VALID   <= 1'b0;
            OVERRUN <= 1'b0;
            primed  <= 1'b0;
            rdl_q   <= 1'b1;
        end else begin
            rdl_q <= RDL;
            if (load) begin
                SAMPLE  <= cand;
                VALID   <= 1'b1;
                OVERRUN <= !rd_edge && (VALID || OVERRUN);
                primed  <= 1'b1;
            end else if (rd_edge) begin
                VALID   <= 1'b0;
                OVERRUN <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: PWM waveform generators, a frame-level reference model that
// counts high samples per 128-clock window, and directed plus randomized scenarios.
module tb_pwm_capture;
    localparam int FL = 128;

    logic        XCK = 1'b0;
    logic        RESETL = 1'b1;
    logic        PW_1 = 1'b0;
    logic        PW_2 = 1'b0;
    logic        RDL = 1'b1;
    logic [15:0] SAMPLE;
    logic        VALID;
    logic        OVERRUN;

    pwm_capture #(.FRAME_BITS(7)) dut (
        .XCK(XCK), .RESETL(RESETL), .PW_1(PW_1), .PW_2(PW_2), .RDL(RDL),
        .SAMPLE(SAMPLE), .VALID(VALID), .OVERRUN(OVERRUN)
    );

    always #5 XCK = ~XCK;

    int n_tests = 0;
    int n_fail = 0;
    logic [15:0] exp_q[$];

    // generator state
    int duty1 = 0, duty2 = 0, ph1 = 0, ph2 = 0;

    // reference model state
    logic pipe1[$];
    logic pipe2[$];
    int   m_edge, m_sum1, m_sum2, m_prev1, m_prev2;
    logic m_primed, m_valid, m_overrun, m_rdl_last;
    logic [15:0] m_sample;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] word_of(input int d1, input int d2);
        logic [6:0] a;
        logic [6:0] b;
        a = d1[6:0];
        b = d2[6:0];
        return {~b[6], b[5:0], a, 2'b00};
    endfunction

    task automatic model_reset();
        pipe1.delete(); pipe2.delete();
        pipe1.push_back(1'b0); pipe1.push_back(1'b0);
        pipe2.push_back(1'b0); pipe2.push_back(1'b0);
        m_edge = 0; m_sum1 = 0; m_sum2 = 0; m_prev1 = 0; m_prev2 = 0;
        m_primed = 1'b0; m_valid = 1'b0; m_overrun = 1'b0; m_rdl_last = 1'b1;
        m_sample = 16'h0000;
    endtask

    // One clock edge of the reference: the DUT sees each input two edges late,
    // and a frame result is the number of high samples across 128 edges.
    task automatic model_edge(input logic p1, input logic p2, input logic rdl);
        logic s1, s2, rd_edge, load;
        int r1, r2;
        logic [15:0] cand;
        s1 = pipe1.pop_front(); pipe1.push_back(p1);
        s2 = pipe2.pop_front(); pipe2.push_back(p2);
        m_edge++;
        m_sum1 += s1 ? 1 : 0;
        m_sum2 += s2 ? 1 : 0;
        rd_edge = !rdl && m_rdl_last;
        m_rdl_last = rdl;
        load = 1'b0;
        if (m_edge % FL == 0) begin
            r1 = (m_sum1 > 127) ? 127 : m_sum1;
            r2 = (m_sum2 > 127) ? 127 : m_sum2;
            m_sum1 = 0;
            m_sum2 = 0;
            cand = word_of(r1, r2);
            load = (r1 == m_prev1) && (r2 == m_prev2) && (!m_primed || cand != m_sample);
            m_prev1 = r1;
            m_prev2 = r2;
            if (load) begin
                m_overrun = rd_edge ? 1'b0 : (m_valid ? 1'b1 : m_overrun);
                m_valid   = 1'b1;
                m_sample  = cand;
                m_primed  = 1'b1;
            end
        end
        if (!load && rd_edge) begin
            m_valid   = 1'b0;
            m_overrun = 1'b0;
        end
    endtask

    task automatic drive_pw(output logic p1, output logic p2);
        p1 = (ph1 % FL) < duty1;
        p2 = (ph2 % FL) < duty2;
        ph1++;
        ph2++;
        PW_1 = p1;
        PW_2 = p2;
    endtask

    task automatic set_duty(input int d1, input int d2, input bit rand_phase);
        duty1 = d1;
        duty2 = d2;
        ph1 = rand_phase ? int'($urandom_range(0, FL - 1)) : 0;
        ph2 = rand_phase ? int'($urandom_range(0, FL - 1)) : 0;
    endtask

    task automatic cycle(input logic rdl_v);
        logic p1, p2;
        @(negedge XCK);
        drive_pw(p1, p2);
        RDL = rdl_v;
        @(posedge XCK);
        model_edge(p1, p2, rdl_v);
        #1;
        check("sample", 32'(SAMPLE), 32'(m_sample));
        check("valid", 32'(VALID), 32'(m_valid));
        check("overrun", 32'(OVERRUN), 32'(m_overrun));
    endtask

    task automatic do_reset(input int hold);
        logic p1, p2;
        @(negedge XCK);
        #2;
        RDL = 1'b1;
        RESETL = 1'b0;
        #1;
        check("rst_sample", 32'(SAMPLE), 32'h0);
        check("rst_valid", 32'(VALID), 32'h0);
        check("rst_overrun", 32'(OVERRUN), 32'h0);
        repeat (hold) begin
            @(negedge XCK);
            drive_pw(p1, p2);
        end
        @(posedge XCK);
        #2;
        RESETL = 1'b1;
        model_reset();
    endtask

    task automatic run_until_next(input int m);
        while (((m_edge + 1) % FL) != m) cycle(1'b1);
    endtask

    task automatic wait_for_word(input string tag, input logic [15:0] w, input int budget);
        bit got;
        got = 1'b0;
        for (int n = 0; n < budget && !got; n++) begin
            cycle(1'b1);
            if (SAMPLE == w && VALID) got = 1'b1;
        end
        check({tag, "_in_time"}, 32'(got), 32'h1);
        check(tag, 32'(SAMPLE), 32'(exp_q.pop_front()));
    endtask

    task automatic pick_new(input int lo1, output int d1, output int d2);
        do begin
            d1 = int'($urandom_range(lo1, 127));
            d2 = int'($urandom_range(0, 127));
        end while (word_of(d1, d2) == m_sample);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit early;
        int a1, a2, c1, c2;
        logic [15:0] s_obs;

        model_reset();
        set_duty(30, 90, 1'b1);
        do_reset(3);
        for (int n = 0; n < 300; n++) cycle(1'b1);

        // mid-frame reset while inputs toggle, then midscale word 0x0000
        do_reset(5);
        set_duty(0, 64, 1'b1);
        early = 1'b0;
        for (int n = 0; n < 255; n++) begin
            cycle(1'b1);
            if (VALID) early = 1'b1;
        end
        check("no_early_load", 32'(early), 32'h0);
        exp_q.push_back(16'h0000);
        wait_for_word("midscale", 16'h0000, 386 - 255);
        cycle(1'b0);
        cycle(1'b1);
        check("read_clears_valid", 32'(VALID), 32'h0);

        // full positive, started at frame offset 37
        run_until_next(38);
        set_duty(127, 127, 1'b0);
        exp_q.push_back(16'h7ffc);
        wait_for_word("full_pos", 16'h7ffc, 386);
        check("full_pos_overrun", 32'(OVERRUN), 32'h0);

        // change without read -> overrun
        set_duty(1, 0, 1'b1);
        exp_q.push_back(16'h8004);
        wait_for_word("change", 16'h8004, 386);
        check("change_valid", 32'(VALID), 32'h1);
        check("change_overrun", 32'(OVERRUN), 32'h1);
        cycle(1'b0);
        check("pulse_valid", 32'(VALID), 32'h0);
        check("pulse_overrun", 32'(OVERRUN), 32'h0);
        cycle(1'b1);

        // two unread loads, then a read edge landing on the load edge
        pick_new(0, a1, a2);
        set_duty(a1, a2, 1'b1);
        exp_q.push_back(word_of(a1, a2));
        wait_for_word("load_a", word_of(a1, a2), 386);
        pick_new(0, a1, a2);
        set_duty(a1, a2, 1'b1);
        exp_q.push_back(word_of(a1, a2));
        wait_for_word("load_b", word_of(a1, a2), 386);
        check("pre_coll_overrun", 32'(OVERRUN), 32'h1);
        pick_new(40, c1, c2);
        run_until_next(127);
        set_duty(c1, c2, 1'b0);
        repeat (257) cycle(1'b1);
        check("pre_coll_sample", 32'(SAMPLE), 32'(word_of(a1, a2)));
        cycle(1'b0);
        check("coll_sample", 32'(SAMPLE), 32'(word_of(c1, c2)));
        check("coll_valid", 32'(VALID), 32'h1);
        check("coll_overrun", 32'(OVERRUN), 32'h0);
        cycle(1'b1);

        // unstable input: duty steps every frame
        run_until_next(127);
        for (int i = 0; i < 8; i++) begin
            set_duty(10 * (i + 1), c2, 1'b0);
            repeat (FL) cycle(1'b1);
        end
        check("unstable_sample", 32'(SAMPLE), 32'(word_of(c1, c2)));
        check("unstable_valid", 32'(VALID), 32'h1);
        set_duty(20, c2, 1'b0);
        exp_q.push_back(word_of(20, c2));
        wait_for_word("hold20", word_of(20, c2), 386);
        s_obs = SAMPLE;
        check("hold20_r1", 32'(s_obs[8:2]), 32'd20);

        // randomized segments with random read strobes
        for (int seg = 0; seg < 14; seg++) begin
            int len;
            set_duty(int'($urandom_range(0, 127)), int'($urandom_range(0, 127)), 1'b1);
            len = int'($urandom_range(128, 450));
            for (int n = 0; n < len; n++)
                cycle(($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1);
        end

        // reset after activity
        do_reset(4);
        for (int n = 0; n < 20; n++) cycle(1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

PWM sample capture block: the receiving end of the two-channel 7-bit PWM DAC link. It measures the duty cycle of PW_1 (low 7 bits) and PW_2 (high 7 bits, MSB inverted on transmit) over 128-clock frames and rebuilds the 16-bit word originally written to the DAC. It sits beside the audio/DAC logic for loop-back self-test and for capturing external PWM sources. Results go to the CPU through a valid/read handshake.

## Interface
Parameters:
- FRAME_BITS, 7: frame counter width; frame length is 2^FRAME_BITS clocks and must equal the transmitter PWM period.

Ports:
- XCK  input  1  system clock; all state updates on the rising edge.
- RESETL  input  1  asynchronous active-low reset.
- PW_1  input  1  low-order PWM channel, asynchronous to XCK.
- PW_2  input  1  high-order PWM channel, asynchronous to XCK.
- RDL  input  1  CPU read strobe, active low, level held for one or more clocks.
- SAMPLE  output  16  reconstructed word.
- VALID  output  1  a new SAMPLE is held and has not been read.
- OVERRUN  output  1  sticky; SAMPLE was replaced while VALID was still set.

## Operation
- Clock and reset: one clock (XCK). Reset is asynchronous and active-low on RESETL.
- Input synchronisers: each PW_x passes through two XCK flops before use. Only the synchronised copies S1 and S2 are used after this point.
- Frame counter FCNT: FRAME_BITS wide, free-running, wraps from 127 to 0. It has no relation to the transmitter phase.
- Accumulators ACC1 and ACC2: 8 bits each.
  - Each clock, ACCx increments when Sx=1.
  - On the terminal cycle (FCNT=127), the frame result is Rx = ACCx + Sx, saturated to 127, and ACCx is cleared to 0 for the next frame.
- Phase independence: the input is periodic with a 128-clock period, so any 128-clock window contains exactly N high cycles for a transmitted value N. No frame alignment is needed.
- Stability filter:
  - PREV1 and PREV2 hold the previous frame's R1 and R2.
  - A frame is "stable" when R1=PREV1 and R2=PREV2.
  - PREV is updated every terminal cycle.
- Update rule: on a stable terminal cycle, SAMPLE is loaded when either condition holds:
  - PRIMED=0, meaning no update since reset; or
  - the candidate word differs from the current SAMPLE.
  - On load, PRIMED is set to 1.
- Word reconstruction:
  - SAMPLE[1:0] = 0
  - SAMPLE[8:2] = R1
  - SAMPLE[14:9] = R2[5:0]
  - SAMPLE[15] = ~R2[6]
- Handshake:
  - A load sets VALID.
  - If VALID was already 1 at load time, OVERRUN is also set.
  - A falling edge of RDL (RDL=0 this clock, 1 the previous clock) clears VALID and OVERRUN on that edge.
  - Holding RDL low clears them only once; a load while RDL stays low sets VALID again.
- Load and read-edge in the same cycle: the load wins. SAMPLE takes the new value, VALID=1, OVERRUN=0 (the read consumed the old value).
- Unstable input: if the value changes every frame, no load ever occurs and SAMPLE keeps its old value.

## Timing
- Reset values:
  - SAMPLE=16'h0000, VALID=0, OVERRUN=0.
  - FCNT=0, ACC1=ACC2=0, PREV1=PREV2=0, PRIMED=0, synchronisers 0, RDL history=1.
- Reset mid-frame discards the partial frame. Counting restarts at FCNT=0 on the first edge after RESETL rises.
- Input-to-accumulator latency: 2 clocks (synchroniser).
- Load latency: SAMPLE and VALID change on the clock edge ending the terminal cycle of the second consecutive matching frame.
  - Worst case from the first edge of a new steady input: 2 + 3×128 clocks.
  - Best case: 2 + 2×128 clocks.
- VALID and OVERRUN clear on the same edge that samples the RDL falling edge. The first low RDL sample is the edge.
- SAMPLE is stable between loads. The CPU may read it at any time while VALID=1.

## Test plan
- Reset: assert RESETL low mid-frame with the inputs toggling -> SAMPLE=0x0000, VALID=0, OVERRUN=0; after release there is no load before 2 full frames.
- Midscale: drive PW_1 high 0/128 and PW_2 high 64/128 (transmitted word 0x0000) -> SAMPLE=0x0000 and VALID=1 within 2+384 clocks.
- Full positive: PW_1 127/128, PW_2 127/128 (word 0x7FFC), with the stimulus started at FCNT offset 37 -> SAMPLE=0x7FFC and the same load latency bound holds.
- Change and overrun:
  - Drive 0x7FFC until it is loaded, then switch to PW_1=1/128, PW_2=0/128 (word 0x8004) with no read -> SAMPLE=0x8004, VALID=1, OVERRUN=1.
  - Pulse RDL low for 1 clock -> VALID=0 and OVERRUN=0 on the next edge.
- Collision: time the RDL falling edge onto the load cycle -> new SAMPLE, VALID=1, OVERRUN=0.
- Unstable input: change the PW_1 duty every frame (10, 20, 30, ...) for 8 frames -> no load, VALID stays at its prior value; then hold 20 -> load with SAMPLE[8:2]=20.
